dp_tap_ctrl: RTL and testbench
==============================

# dp_tap_ctrl

IEEE 1149.1 TAP controller for the debug transport path. It runs the 16-state TAP state machine from TMS and owns the 5-bit instruction register (shift stage plus update stage). It drives the latched instruction to the instruction decoder (`pdi`). It also generates the capture/shift/update strobes and the TDO multiplexing for the data register selected by the decoder (IDCODE, DTMCS, DMI, BYPASS).

## Interface
Parameters:
- `IR_W`, 5: instruction register width.
- `IR_RST`, 5'h01: instruction loaded on reset and in Test-Logic-Reset (IDCODE).
- `IR_CAP`, 5'h01: value loaded into the IR shift stage in Capture-IR.

Ports. One clock; reset is synchronous and active-high.
- `tck` in 1: TAP clock; all state updates on the rising edge.
- `trst` in 1: synchronous active-high reset.
- `tms` in 1: test mode select.
- `tdi` in 1: serial data in.
- `bsr_sel` in 4: data-register select from the instruction decoder.
- `dr_so` in 1: serial out (LSB) of the selected external data register.
- `ir` out IR_W: latched instruction, to decoder `pdi`.
- `tap_state` out 4: current state encoding.
- `capture_dr` out 1: high while in Capture-DR.
- `shift_dr` out 1: high while in Shift-DR.
- `update_dr` out 1: high while in Update-DR.
- `tlr` out 1: high while in Test-Logic-Reset.
- `tdo` out 1: serial data out.
- `tdo_en` out 1: high in Shift-IR and Shift-DR.

## Operation
- State encoding (fixed, 1149.1 standard):
  - TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1
  - PAU_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A
  - EX1_IR=9, PAU_IR=B, EX2_IR=8, UPD_IR=D
- Transitions are the 1149.1 ones. Listed as state: TMS=0 → next, TMS=1 → next.
  - TLR: 0→RTI, 1→TLR.
  - RTI: 0→RTI, 1→SEL_DR.
  - SEL_DR: 0→CAP_DR, 1→SEL_IR.
  - SEL_IR: 0→CAP_IR, 1→TLR.
  - CAP_x: 0→SH_x, 1→EX1_x.
  - SH_x: 0→SH_x, 1→EX1_x.
  - EX1_x: 0→PAU_x, 1→UPD_x.
  - PAU_x: 0→PAU_x, 1→EX2_x.
  - EX2_x: 0→SH_x, 1→UPD_x.
  - UPD_x: 0→RTI, 1→SEL_DR.
- IR shift stage `ir_sh`, on rising edges:
  - In CAP_IR: load IR_CAP.
  - In SH_IR: `ir_sh <= {tdi, ir_sh[IR_W-1:1]}`.
  - Otherwise: hold.
- IR update stage `ir`:
  - In UPD_IR: `ir <= ir_sh`.
  - In TLR: `ir <= IR_RST`.
  - Otherwise: hold.
- Strobes are pure decodes of the current state. An external DR acts on the rising edge that leaves that state.
- `tdo` is a combinational mux:
  - In SH_IR: `ir_sh[0]`.
  - In SH_DR: the DR source (see Configuration).
  - Otherwise: 0.
- `tdo_en` is the OR of the SH_IR and SH_DR decodes.

## Timing
- Reset values while `trst`=1:
  - `tap_state`=F, `ir`=IR_RST, `ir_sh`=IR_CAP, bypass reg=0.
  - Outputs: `tlr`=1, `capture_dr`=`shift_dr`=`update_dr`=0, `tdo`=0, `tdo_en`=0.
- `trst` has priority over TMS at any point, including mid-shift. An IR scan interrupted by reset leaves `ir`=IR_RST; the partial `ir_sh` is discarded.
- Five consecutive rising edges with TMS=1 reach TLR from any state.
- Latency: `ir` changes on the rising edge that exits UPD_IR. It is visible to the decoder one cycle after UPD_IR is shown on `tap_state`.
- Pause states hold every register: `ir_sh`, the bypass register and `ir` are unchanged for any number of cycles.
- Exit1 and Exit2 do not shift.
- The last shifted bit is taken on the edge leaving SH_x with TMS=1.

## Configuration
- Macro `DP_TAP_BYPASS_EN`.
- Defined:
  - The block contains a 1-bit bypass register.
  - When `bsr_sel`==SEL_BYPASS, the register loads 0 in CAP_DR and loads `tdi` in SH_DR.
  - `tdo` in SH_DR is the bypass register; `dr_so` is ignored for that selection.
  - For any other selection, `tdo` in SH_DR is `dr_so`.
- Not defined:
  - No bypass register.
  - `bsr_sel` is unused.
  - `tdo` in SH_DR is always `dr_so`.

## Test plan
- Reset: assert `trst` one cycle from arbitrary state and TMS → `tap_state`=F, `ir`=5'h01, `tlr`=1, `tdo_en`=0.
- TMS=1 for 5 edges starting from SH_DR, PAU_IR and RTI → `tap_state`=F after exactly the 5th edge in each case.
- IR scan from RTI:
  - TMS 1,1,0,0 → SH_IR.
  - Shift 5'h11 LSB first, TMS=1 on the 5th bit, then TMS=1 → UPD_IR.
  - Required: `tdo` sequence 1,0,0,0,0; `ir`=5'h11 one edge after UPD_IR.
- DR path:
  - TMS 1,0,0 from RTI → `capture_dr`=1 for one cycle, then `shift_dr`=1 while TMS=0.
  - `tdo` follows `dr_so`.
  - Exit via EX1/UPD → `update_dr`=1 for exactly one cycle.
- Pause/resume: enter PAU_IR after 2 bits of a 5-bit IR shift, hold 10 cycles, EX2 → SH_IR, finish → `ir` equals the full shifted value.
- `DP_TAP_BYPASS_EN` with `bsr_sel`=SEL_BYPASS: shift `tdi` 1,0,1,1 → `tdo` 0,1,0,1, with `dr_so` held at 1.

Source files
------------

// File: rtl/dp_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, 5-bit IR (shift + update stages), DR strobes and TDO mux.
// Optional 1-bit bypass register is built when DP_TAP_BYPASS_EN is defined.
module dp_tap_ctrl #(
    parameter int              IR_W       = 5,
    parameter logic [IR_W-1:0] IR_RST     = 5'h01,
    parameter logic [IR_W-1:0] IR_CAP     = 5'h01,
    parameter logic [3:0]      SEL_BYPASS = 4'hF
) (
    input  logic            tck,
    input  logic            trst,
    input  logic            tms,
    input  logic            tdi,
    input  logic [3:0]      bsr_sel,
    input  logic            dr_so,
    output logic [IR_W-1:0] ir,
    output logic [3:0]      tap_state,
    output logic            capture_dr,
    output logic            shift_dr,
    output logic            update_dr,
    output logic            tlr,
    output logic            tdo,
    output logic            tdo_en
);

    typedef enum logic [3:0] {
        EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
        SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
        EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
        RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
    } tap_state_e;

    tap_state_e      state_q, state_d;
    logic [IR_W-1:0] ir_sh_q, ir_q;
    logic            capture_dr_q, shift_dr_q, update_dr_q, shift_ir_q, tlr_q;
    logic            dr_src;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

`ifdef DP_TAP_BYPASS_EN
    logic byp_q;
    assign dr_src = (bsr_sel == SEL_BYPASS) ? byp_q : dr_so;
`else
    logic unused_bsr;
    assign unused_bsr = ^bsr_sel;
    assign dr_src     = dr_so;
`endif

    // Strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge tck) begin
        if (trst) begin
            state_q      <= TLR;
            ir_q         <= IR_RST;
            ir_sh_q      <= IR_CAP;
            capture_dr_q <= 1'b0;
            shift_dr_q   <= 1'b0;
            update_dr_q  <= 1'b0;
            shift_ir_q   <= 1'b0;
            tlr_q        <= 1'b1;
`ifdef DP_TAP_BYPASS_EN
            byp_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            capture_dr_q <= (state_d == CAP_DR);
            shift_dr_q   <= (state_d == SH_DR);
            update_dr_q  <= (state_d == UPD_DR);
            shift_ir_q   <= (state_d == SH_IR);
            tlr_q        <= (state_d == TLR);
            case (state_q)
                CAP_IR: ir_sh_q <= IR_CAP;
                SH_IR:  ir_sh_q <= {tdi, ir_sh_q[IR_W-1:1]};
                UPD_IR: ir_q    <= ir_sh_q;
                TLR:    ir_q    <= IR_RST;
                default: ;
            endcase
`ifdef DP_TAP_BYPASS_EN
            if (bsr_sel == SEL_BYPASS) begin
                if (state_q == CAP_DR)
                    byp_q <= 1'b0;
                else if (state_q == SH_DR)
                    byp_q <= tdi;
            end
`endif
        end
    end

    assign ir         = ir_q;
    assign tap_state  = state_q;
    assign capture_dr = capture_dr_q;
    assign shift_dr   = shift_dr_q;
    assign update_dr  = update_dr_q;
    assign tlr        = tlr_q;
    assign tdo_en     = shift_ir_q | shift_dr_q;
    assign tdo        = shift_ir_q ? ir_sh_q[0] : (shift_dr_q ? dr_src : 1'b0);

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Directed testbench for dp_tap_ctrl: reset, TLR recovery, IR scan, DR strobes, pause/resume, bypass.
module tb_dp_tap_ctrl;

    logic       tck = 1'b0;
    logic       trst, tms, tdi, dr_so;
    logic [3:0] bsr_sel;
    logic [4:0] ir;
    logic [3:0] tap_state;
    logic       capture_dr, shift_dr, update_dr, tlr, tdo, tdo_en;

    int total = 0;
    int bad   = 0;

    dp_tap_ctrl dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .bsr_sel(bsr_sel), .dr_so(dr_so),
        .ir(ir), .tap_state(tap_state), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .tlr(tlr), .tdo(tdo), .tdo_en(tdo_en)
    );

    always #5 tck = ~tck;

    task automatic step(input logic tms_v, input logic tdi_v);
        tms = tms_v;
        tdi = tdi_v;
        @(posedge tck);
        #1;
    endtask

    task automatic go_tlr();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        trst = 1'b1;
        step(1'b0, 1'b1);
        trst = 1'b0;
        total++;
        if (tap_state !== 4'hF) begin bad++; $display("FAIL reset_state got=%h exp=F", tap_state); end
        total++;
        if (ir !== 5'h01) begin bad++; $display("FAIL reset_ir got=%h exp=01", ir); end
        total++;
        if (tlr !== 1'b1 || tdo_en !== 1'b0 || tdo !== 1'b0) begin
            bad++; $display("FAIL reset_out tlr=%b tdo_en=%b tdo=%b exp=1,0,0", tlr, tdo_en, tdo);
        end
        total++;
        if ({capture_dr, shift_dr, update_dr} !== 3'b000) begin
            bad++; $display("FAIL reset_strobes got=%b exp=000", {capture_dr, shift_dr, update_dr});
        end
    endtask

    task automatic test_tlr5();
        // from RTI
        step(1'b0, 1'b0);
        total++;
        if (tap_state !== 4'hC) begin bad++; $display("FAIL tlr5_rti_entry got=%h exp=C", tap_state); end
        go_tlr();
        total++;
        if (tap_state !== 4'hF) begin bad++; $display("FAIL tlr5_from_rti got=%h exp=F", tap_state); end
        // from SH_DR
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        total++;
        if (tap_state !== 4'h2) begin bad++; $display("FAIL tlr5_shdr_entry got=%h exp=2", tap_state); end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        total++;
        if (tap_state !== 4'h4) begin bad++; $display("FAIL tlr5_shdr_edge4 got=%h exp=4", tap_state); end
        step(1'b1, 1'b0);
        total++;
        if (tap_state !== 4'hF) begin bad++; $display("FAIL tlr5_from_shdr got=%h exp=F", tap_state); end
        // from PAU_IR
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
        total++;
        if (tap_state !== 4'hB) begin bad++; $display("FAIL tlr5_pauir_entry got=%h exp=B", tap_state); end
        go_tlr();
        total++;
        if (tap_state !== 4'hF) begin bad++; $display("FAIL tlr5_from_pauir got=%h exp=F", tap_state); end
    endtask

    task automatic test_ir_scan();
        logic [4:0] val;
        val = 5'h11;
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        total++;
        if (tap_state !== 4'hA || tdo_en !== 1'b1) begin
            bad++; $display("FAIL ir_shift_entry state=%h tdo_en=%b exp=A,1", tap_state, tdo_en);
        end
        total++;
        if (tdo !== 1'b1) begin bad++; $display("FAIL ir_tdo_bit0 got=%b exp=1", tdo); end
        for (int i = 0; i < 5; i++) begin
            step(i == 4, val[i]);
            if (i < 4) begin
                total++;
                if (tdo !== 1'b0) begin bad++; $display("FAIL ir_tdo_bit%0d got=%b exp=0", i + 1, tdo); end
            end
        end
        total++;
        if (tap_state !== 4'h9 || tdo_en !== 1'b0 || tdo !== 1'b0) begin
            bad++; $display("FAIL ir_exit1 state=%h tdo_en=%b tdo=%b exp=9,0,0", tap_state, tdo_en, tdo);
        end
        step(1'b1, 1'b0);
        total++;
        if (tap_state !== 4'hD || ir !== 5'h01) begin
            bad++; $display("FAIL ir_in_update state=%h ir=%h exp=D,01", tap_state, ir);
        end
        step(1'b0, 1'b0);
        total++;
        if (tap_state !== 4'hC || ir !== 5'h11) begin
            bad++; $display("FAIL ir_latched state=%h ir=%h exp=C,11", tap_state, ir);
        end
    endtask

    task automatic test_dr_path();
        bsr_sel = 4'h0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        total++;
        if ({capture_dr, shift_dr, update_dr, tdo_en} !== 4'b1000 || tap_state !== 4'h6) begin
            bad++; $display("FAIL dr_capture cap/sh/upd/en=%b state=%h exp=1000,6",
                            {capture_dr, shift_dr, update_dr, tdo_en}, tap_state);
        end
        step(1'b0, 1'b0);
        total++;
        if ({capture_dr, shift_dr, update_dr, tdo_en} !== 4'b0101) begin
            bad++; $display("FAIL dr_shift cap/sh/upd/en=%b exp=0101", {capture_dr, shift_dr, update_dr, tdo_en});
        end
        dr_so = 1'b1; #1;
        total++;
        if (tdo !== 1'b1) begin bad++; $display("FAIL dr_tdo_hi got=%b exp=1", tdo); end
        dr_so = 1'b0; #1;
        total++;
        if (tdo !== 1'b0) begin bad++; $display("FAIL dr_tdo_lo got=%b exp=0", tdo); end
        step(1'b0, 1'b0);
        total++;
        if (shift_dr !== 1'b1 || tap_state !== 4'h2) begin
            bad++; $display("FAIL dr_shift_hold sh=%b state=%h exp=1,2", shift_dr, tap_state);
        end
        step(1'b1, 1'b0);
        total++;
        if ({shift_dr, update_dr} !== 2'b00 || tap_state !== 4'h1) begin
            bad++; $display("FAIL dr_exit1 sh/upd=%b state=%h exp=00,1", {shift_dr, update_dr}, tap_state);
        end
        step(1'b1, 1'b0);
        total++;
        if (update_dr !== 1'b1 || tap_state !== 4'h5) begin
            bad++; $display("FAIL dr_update upd=%b state=%h exp=1,5", update_dr, tap_state);
        end
        dr_so = 1'b1;
        step(1'b0, 1'b0);
        total++;
        if (update_dr !== 1'b0 || tdo !== 1'b0 || tap_state !== 4'hC) begin
            bad++; $display("FAIL dr_after_update upd=%b tdo=%b state=%h exp=0,0,C", update_dr, tdo, tap_state);
        end
        dr_so = 1'b0;
    endtask

    task automatic test_pause();
        logic [4:0] val;
        val = 5'h16;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, val[0]);
        step(1'b1, val[1]);
        step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        total++;
        if (tap_state !== 4'hB || ir !== 5'h11 || tdo_en !== 1'b0) begin
            bad++; $display("FAIL pause_hold state=%h ir=%h tdo_en=%b exp=B,11,0", tap_state, ir, tdo_en);
        end
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        total++;
        if (tap_state !== 4'hA || tdo !== 1'b0) begin
            bad++; $display("FAIL pause_resume state=%h tdo=%b exp=A,0", tap_state, tdo);
        end
        step(1'b0, val[2]);
        step(1'b0, val[3]);
        step(1'b1, val[4]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        total++;
        if (ir !== 5'h16) begin bad++; $display("FAIL pause_ir got=%h exp=16", ir); end
    endtask

    task automatic test_reset_midshift();
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        trst = 1'b1;
        step(1'b0, 1'b1);
        trst = 1'b0;
        total++;
        if (tap_state !== 4'hF || ir !== 5'h01 || tdo_en !== 1'b0) begin
            bad++; $display("FAIL midshift_reset state=%h ir=%h tdo_en=%b exp=F,01,0", tap_state, ir, tdo_en);
        end
    endtask

`ifdef DP_TAP_BYPASS_EN
    task automatic test_bypass();
        logic [3:0] din, dexp;
        din  = 4'b1101;
        dexp = 4'b1010;
        bsr_sel = 4'hF;
        dr_so   = 1'b1;
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tdi = din[i]; #1;
            total++;
            if (tdo !== dexp[i]) begin bad++; $display("FAIL bypass_bit%0d got=%b exp=%b", i, tdo, dexp[i]); end
            step(1'b0, din[i]);
        end
        go_tlr();
        bsr_sel = 4'h0;
        dr_so   = 1'b0;
    endtask
`endif

    initial begin
        trst = 1'b1; tms = 1'b1; tdi = 1'b0; dr_so = 1'b0; bsr_sel = 4'h0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        trst = 1'b0;
        test_reset();
        test_tlr5();
        test_ir_scan();
        test_dr_path();
        test_pause();
        test_reset_midshift();
`ifdef DP_TAP_BYPASS_EN
        test_bypass();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
